complex_decoder_scheduler: RTL and testbench
============================================

COMPLEX_DECODER_SCHEDULER -- requirements
Module: complex_decoder_scheduler

Interface
REQ-001 The block SHALL have parameter element_width, default 64, meaning the width of one element.
REQ-002 The block SHALL have parameter no_of_row_by_vector_modules, default 4; WORD_W = element_width*no_of_row_by_vector_modules (default 256).
REQ-003 The block SHALL have parameter NUM_SRC, default 2, legal range 2..8, meaning the number of word sources sharing the decoder.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 src_valid  input  NUM_SRC  bit i set: source i presents a word.
REQ-008 src_data  input  NUM_SRC*WORD_W  source i word in slice [i*WORD_W +: WORD_W].
REQ-009 src_ack  output  NUM_SRC  one-cycle pulse, one-hot: the granted source's word was consumed; that source SHALL update src_valid and src_data by the next edge.
REQ-010 dec_in  output  WORD_W  registered word to the decoder input.
REQ-011 decoder_read_now  output  1  registered decoder strobe; one cycle high per beat.
REQ-012 outsider_read_now  input  1  decoder pair-complete flag; high in the cycle after the strobe that wrote the low half.
REQ-013 pair_valid  output  1  decoder output holds a complete pair.
REQ-014 pair_ready  input  1  downstream accepts the pair.
REQ-015 pair_src  output  3  source index of the presented pair.
REQ-016 sync_err  output  1  sticky flag: decoder half-phase mismatch detected.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 States SHALL be RS_STROBE, RS_CHECK, IDLE, HI_GAP, LO_WAIT, LO_CHECK and PRESENT; "strobe cycle" is a cycle with decoder_read_now high.
REQ-019 RS_STROBE SHALL drive dec_in=0 and produce one strobe cycle S; RS_CHECK SHALL sample outsider_read_now in S+1: if 1 go to IDLE, else go to RS_STROBE (next strobe in S+2).
REQ-020 In IDLE the block SHALL grant round-robin among set src_valid bits, searching from last_grant+1 modulo NUM_SRC; last_grant SHALL reset to NUM_SRC-1, so source 0 has first priority.
REQ-021 On grant g at edge t the block SHALL load dec_in with src_data slice g, store g, update last_grant, and go to HI_GAP; decoder_read_now and src_ack[g] SHALL be high in cycle t+1 (high-half beat H).
REQ-022 In LO_WAIT the grant SHALL stay locked to g; other sources SHALL NOT be acked; the block SHALL wait with no timeout for src_valid[g].
REQ-023 If outsider_read_now is high in H+1, the block SHALL set sync_err, discard the pair, and go to RS_STROBE; this check SHALL take priority over a word-1 capture in the same cycle.
REQ-024 The low-half strobe cycle L SHALL be at least H+2, with src_ack[g] high in L; in L+1 (LO_CHECK) outsider_read_now high SHALL move to PRESENT with pair_valid high from L+2; low SHALL set sync_err, discard, go to RS_STROBE.
REQ-025 In PRESENT pair_valid and pair_src=g SHALL hold until pair_valid&&pair_ready at an edge; pair_valid SHALL be low the next cycle and state SHALL return to IDLE; no strobe SHALL be issued in PRESENT.
REQ-026 Minimum grant-edge-to-pair_valid latency SHALL be 5 cycles; back-to-back pair throughput SHALL be at most one pair per 6 cycles.
REQ-027 Outside listed strobe cycles, decoder_read_now and src_ack SHALL be 0; dec_in SHALL hold its value.
REQ-028 Discarded words SHALL NOT be re-requested; sync_err SHALL clear only on reset.

Reset
REQ-029 While rst_n=0: decoder_read_now=0, src_ack=0, dec_in=0, pair_valid=0, pair_src=0, sync_err=0, busy=1, state=RS_STROBE, last_grant=NUM_SRC-1.
REQ-030 Reset asserted mid-pair or mid-present SHALL abandon the pair without ack or pair_valid; after release, resync SHALL complete before any grant.

Verification
REQ-031 Release reset with the decoder aligned -> two resync strobes, dec_in=0, IDLE after the second check, sync_err=0.
REQ-032 Source 0 presents 0xA1.. then 0xB2.. with pair_ready=1 -> src_ack[0] in H and L, decoder low/high halves=B2../A1.., pair_valid at grant+5, pair_src=0.
REQ-033 Both sources valid continuously -> grants alternate 0,1,0,1; no ack to the non-granted source while locked.
REQ-034 Source 1 drops valid for 3 cycles between words -> L delayed 3 cycles, no other source acked, pair completes correctly.
REQ-035 Force outsider_read_now=1 in H+1 -> sync_err=1, pair discarded, resync strobes with dec_in=0, then normal grants.
REQ-036 Assert rst_n=0 in PRESENT with pair_ready=0 -> pair_valid=0 immediately, resync after release.

Source files
------------

// File: rtl/complex_decoder_scheduler.sv
// Round-robin scheduler that feeds pairs of words from several sources into a
// two-half decoder, tracks the decoder's half phase and resynchronises it on mismatch.
module complex_decoder_scheduler #(
  parameter int element_width               = 64,
  parameter int no_of_row_by_vector_modules = 4,
  parameter int NUM_SRC                     = 2,
  localparam int WORD_W = element_width * no_of_row_by_vector_modules,
  localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*WORD_W-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_ack,
  output logic [WORD_W-1:0]         dec_in,
  output logic                      decoder_read_now,
  input  logic                      outsider_read_now,
  output logic                      pair_valid,
  input  logic                      pair_ready,
  output logic [2:0]                pair_src,
  output logic                      sync_err,
  output logic                      busy
);

  typedef enum logic [2:0] {
    RS_STROBE,
    RS_CHECK,
    IDLE,
    HI_GAP,
    LO_WAIT,
    LO_CHECK,
    PRESENT
  } state_e;

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  dec_in_q, dec_in_d;
  logic               strobe_q, strobe_d;
  logic [NUM_SRC-1:0] ack_q, ack_d;
  logic               pair_valid_q, pair_valid_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic               sync_err_q, sync_err_d;

  logic               rr_found;
  logic [IDX_W-1:0]   rr_idx;
  logic [IDX_W-1:0]   rr_cand;
  logic [WORD_W-1:0]  rr_word;
  logic [WORD_W-1:0]  grant_word;

  // Round-robin search starting one past the last granted source.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_cand  = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      rr_cand = IDX_W'((int'(last_grant_q) + k) % NUM_SRC);
      if (!rr_found && src_valid[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  assign rr_word    = src_data[int'(rr_idx) * WORD_W +: WORD_W];
  assign grant_word = src_data[int'(grant_q) * WORD_W +: WORD_W];

  // The strobe register doubles as a phase marker: in HI_GAP, LO_CHECK and
  // RS_STROBE a high strobe_q means "this is the strobe cycle itself", so the
  // decoder flag is only examined in the cycle after it.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    dec_in_d     = dec_in_q;
    strobe_d     = 1'b0;
    ack_d        = '0;
    pair_valid_d = pair_valid_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    sync_err_d   = sync_err_q;

    unique case (state_q)
      RS_STROBE: begin
        if (strobe_q) begin
          state_d = RS_CHECK;
        end else begin
          strobe_d = 1'b1;
          dec_in_d = '0;
        end
      end

      RS_CHECK: begin
        if (outsider_read_now) begin
          state_d = IDLE;
        end else begin
          state_d  = RS_STROBE;
          strobe_d = 1'b1;
          dec_in_d = '0;
        end
      end

      IDLE: begin
        if (rr_found) begin
          grant_d        = rr_idx;
          last_grant_d   = rr_idx;
          dec_in_d       = rr_word;
          strobe_d       = 1'b1;
          ack_d[rr_idx]  = 1'b1;
          state_d        = HI_GAP;
        end
      end

      HI_GAP: begin
        if (!strobe_q) begin
          // A pair-complete flag right after the high half means the decoder
          // is a half out of phase; that wins over capturing the low word.
          if (outsider_read_now) begin
            sync_err_d = 1'b1;
            state_d    = RS_STROBE;
            strobe_d   = 1'b1;
            dec_in_d   = '0;
          end else if (src_valid[grant_q]) begin
            dec_in_d       = grant_word;
            strobe_d       = 1'b1;
            ack_d[grant_q] = 1'b1;
            state_d        = LO_CHECK;
          end else begin
            state_d = LO_WAIT;
          end
        end
      end

      LO_WAIT: begin
        if (src_valid[grant_q]) begin
          dec_in_d       = grant_word;
          strobe_d       = 1'b1;
          ack_d[grant_q] = 1'b1;
          state_d        = LO_CHECK;
        end
      end

      LO_CHECK: begin
        if (!strobe_q) begin
          if (outsider_read_now) begin
            pair_valid_d = 1'b1;
            state_d      = PRESENT;
          end else begin
            sync_err_d = 1'b1;
            state_d    = RS_STROBE;
            strobe_d   = 1'b1;
            dec_in_d   = '0;
          end
        end
      end

      PRESENT: begin
        if (pair_ready) begin
          pair_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d  = RS_STROBE;
        dec_in_d = '0;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RS_STROBE;
      dec_in_q     <= '0;
      strobe_q     <= 1'b0;
      ack_q        <= '0;
      pair_valid_q <= 1'b0;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_SRC - 1);
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      dec_in_q     <= dec_in_d;
      strobe_q     <= strobe_d;
      ack_q        <= ack_d;
      pair_valid_q <= pair_valid_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign src_ack          = ack_q;
  assign dec_in           = dec_in_q;
  assign decoder_read_now = strobe_q;
  assign pair_valid       = pair_valid_q;
  assign pair_src         = 3'(grant_q);
  assign sync_err         = sync_err_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_complex_decoder_scheduler.sv
// Self-checking bench: source and decoder models, a pair scoreboard, a
// vector table of single-source pairs and hand-written corner sequences.
module tb_complex_decoder_scheduler;

  localparam int EW = 64;
  localparam int NR = 4;
  localparam int NS = 2;
  localparam int W  = EW * NR;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NS-1:0]     src_valid = '0;
  logic [NS*W-1:0]   src_data = '0;
  logic [NS-1:0]     src_ack;
  logic [W-1:0]      dec_in;
  logic              decoder_read_now;
  logic              outsider_read_now = 1'b0;
  logic              pair_valid;
  logic              pair_ready = 1'b0;
  logic [2:0]        pair_src;
  logic              sync_err;
  logic              busy;

  complex_decoder_scheduler #(
    .element_width(EW),
    .no_of_row_by_vector_modules(NR),
    .NUM_SRC(NS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .src_valid(src_valid),
    .src_data(src_data),
    .src_ack(src_ack),
    .dec_in(dec_in),
    .decoder_read_now(decoder_read_now),
    .outsider_read_now(outsider_read_now),
    .pair_valid(pair_valid),
    .pair_ready(pair_ready),
    .pair_src(pair_src),
    .sync_err(sync_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int src; logic [W-1:0] w0; logic [W-1:0] w1; int gap; int rdy_dly; } vec_t;
  typedef struct { int src; logic [W-1:0] hi; logic [W-1:0] lo; int lat; } exp_t;
  typedef struct { logic [W-1:0] data; int dly; } word_t;

  int     checks = 0;
  int     failures = 0;
  exp_t   sb[$];
  word_t  srcq[NS][$];
  int     wt[NS];
  int     cyc = 0;
  int     h_cyc = 0;
  int     lock_src = 0;
  bit     mon_hi = 1'b1;
  bit     pv_prev = 1'b0;
  logic   force_or = 1'b0;
  logic [W-1:0] dec_hi = '0;
  logic [W-1:0] dec_lo = '0;
  bit     dec_hi_next = 1'b1;
  int     exp_last = NS - 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mkw(input logic [7:0] tag);
    return {(W/8){tag}};
  endfunction

  task automatic load(input int s, input logic [W-1:0] d, input int dly);
    word_t e;
    e.data = d;
    e.dly  = dly;
    if (srcq[s].size() == 0) wt[s] = dly;
    srcq[s].push_back(e);
  endtask

  // Decoder model: strobes alternately write the high and low halves; the
  // flag is high in the cycle after the low-half strobe.
  initial begin
    logic         s;
    logic [W-1:0] d;
    logic         flag;
    flag = 1'b0;
    forever begin
      @(negedge clk);
      s = decoder_read_now;
      d = dec_in;
      @(posedge clk);
      #2;
      if (s) begin
        if (dec_hi_next) begin
          dec_hi = d; dec_hi_next = 1'b0; flag = 1'b0;
        end else begin
          dec_lo = d; dec_hi_next = 1'b1; flag = 1'b1;
        end
      end else begin
        flag = 1'b0;
      end
      outsider_read_now = flag | force_or;
    end
  end

  // Monitor, scoreboard compare and source model, all on the falling edge.
  initial begin
    logic [NS-1:0] ack;
    int            idx;
    exp_t          e;
    for (int i = 0; i < NS; i++) wt[i] = 0;
    forever begin
      @(negedge clk);
      cyc++;
      ack = src_ack;
      if (ack != '0) begin
        check("ack_onehot", W'($onehot(ack)), W'(1));
        idx = 0;
        for (int i = 0; i < NS; i++) if (ack[i]) idx = i;
        if (mon_hi) begin
          lock_src = idx; h_cyc = cyc; mon_hi = 1'b0;
        end else begin
          check("ack_locked_src", W'(idx), W'(lock_src));
          mon_hi = 1'b1;
        end
      end
      if (pair_valid) begin
        check("no_strobe_in_present", W'(decoder_read_now), W'(0));
        if (!pv_prev) begin
          if (sb.size() == 0) check("unexpected_pair", W'(1), W'(0));
          else check("pair_latency", W'(cyc - h_cyc), W'(sb[0].lat));
        end
        if (pair_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_accept", W'(1), W'(0));
          end else begin
            e = sb.pop_front();
            check("pair_src", W'(pair_src), W'(e.src));
            check("pair_hi", dec_hi, e.hi);
            check("pair_lo", dec_lo, e.lo);
          end
        end
      end
      pv_prev = pair_valid;
      for (int i = 0; i < NS; i++) begin
        if (ack[i] && srcq[i].size() > 0) begin
          void'(srcq[i].pop_front());
          wt[i] = (srcq[i].size() > 0) ? srcq[i][0].dly + 1 : 0;
        end else if (wt[i] > 0) begin
          wt[i]--;
        end
        src_valid[i] = (srcq[i].size() > 0) && (wt[i] == 0);
        src_data[i*W +: W] = (srcq[i].size() > 0) ? srcq[i][0].data : '0;
      end
    end
  end

  task automatic resync_check(input string name, input int exp_strobes);
    int  n = 0;
    int  t = 0;
    bit  zero_ok = 1'b1;
    while (busy !== 1'b0 && t < 30) begin
      @(negedge clk);
      t++;
      if (decoder_read_now) begin
        n++;
        if (dec_in !== '0) zero_ok = 1'b0;
      end
    end
    check({name, "_idle"}, W'(busy), W'(0));
    check({name, "_strobes"}, W'(n), W'(exp_strobes));
    check({name, "_dec_zero"}, W'(zero_ok), W'(1));
  endtask

  task automatic wait_pv(input logic level, input int maxc, input string name);
    int n = 0;
    while (pair_valid !== level && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check({name, "_reached"}, W'(pair_valid), W'(level));
  endtask

  task automatic wait_sb(input int maxc, input string name);
    int n = 0;
    while (sb.size() != 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, W'(sb.size()), W'(0));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    logic [W-1:0] wa[NS][4];
    int   first;
    int   second;
    int   n;

    vecs[0] = '{0, mkw(8'hA1), mkw(8'hB2), 0, 0};
    vecs[1] = '{1, mkw(8'hC3), mkw(8'hD4), 3, 2};
    vecs[2] = '{0, mkw(8'hE5), mkw(8'hF6), 1, 0};
    vecs[3] = '{1, mkw(8'h17), mkw(8'h28), 0, 3};

    repeat (3) @(posedge clk);
    #1;
    check("rst_strobe", W'(decoder_read_now), W'(0));
    check("rst_ack", W'(src_ack), W'(0));
    check("rst_dec_in", dec_in, '0);
    check("rst_pair_valid", W'(pair_valid), W'(0));
    check("rst_pair_src", W'(pair_src), W'(0));
    check("rst_sync_err", W'(sync_err), W'(0));
    check("rst_busy", W'(busy), W'(1));

    step();
    rst_n = 1'b1;
    resync_check("resync_init", 2);
    check("init_sync_err", W'(sync_err), W'(0));

    // Single-source pairs, with low-word gaps and downstream backpressure.
    for (int v = 0; v < 4; v++) begin
      step();
      sb.push_back('{vecs[v].src, vecs[v].w0, vecs[v].w1, 4 + vecs[v].gap});
      load(vecs[v].src, vecs[v].w0, 0);
      load(vecs[v].src, vecs[v].w1, vecs[v].gap);
      pair_ready = (vecs[v].rdy_dly == 0);
      wait_pv(1'b1, 40, "vec_pv_rise");
      for (int k = 0; k < vecs[v].rdy_dly; k++) begin
        @(negedge clk);
        check("vec_pv_hold", W'(pair_valid), W'(1));
        check("vec_src_hold", W'(pair_src), W'(vecs[v].src));
      end
      step();
      pair_ready = 1'b1;
      wait_pv(1'b0, 10, "vec_pv_fall");
      check("vec_idle_after_pair", W'(busy), W'(0));
      exp_last = vecs[v].src;
    end
    check("table_sb_empty", W'(sb.size()), W'(0));

    // Both sources continuously valid: grants must alternate.
    step();
    first  = (exp_last + 1) % NS;
    second = (first + 1) % NS;
    for (int s = 0; s < NS; s++)
      for (int k = 0; k < 4; k++) begin
        wa[s][k] = mkw(8'(8'h40 + s * 16 + k));
        load(s, wa[s][k], 0);
      end
    sb.push_back('{first,  wa[first][0],  wa[first][1],  4});
    sb.push_back('{second, wa[second][0], wa[second][1], 4});
    sb.push_back('{first,  wa[first][2],  wa[first][3],  4});
    sb.push_back('{second, wa[second][2], wa[second][3], 4});
    pair_ready = 1'b1;
    wait_sb(200, "alternate");
    wait_pv(1'b0, 10, "alternate_pv_fall");
    exp_last = second;

    // Decoder flags pair-complete right after the high half.
    step();
    load(0, mkw(8'h91), 0);
    load(0, mkw(8'h92), 0);
    load(0, mkw(8'h93), 0);
    n = 0;
    while (src_ack == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("err_first_ack", W'(src_ack), W'(1));
    step();
    force_or = 1'b1;
    step();
    force_or = 1'b0;
    mon_hi = 1'b1;
    check("sync_err_set", W'(sync_err), W'(1));
    resync_check("resync_err", 1);
    sb.push_back('{0, mkw(8'h92), mkw(8'h93), 4});
    wait_sb(60, "after_err");
    check("sync_err_sticky", W'(sync_err), W'(1));
    wait_pv(1'b0, 10, "after_err_pv_fall");

    // Reset while a pair is being presented and held.
    step();
    pair_ready = 1'b0;
    sb.push_back('{1, mkw(8'hC7), mkw(8'hD8), 4});
    load(1, mkw(8'hC7), 0);
    load(1, mkw(8'hD8), 0);
    wait_pv(1'b1, 40, "rstpres_pv_rise");
    check("rstpres_src", W'(pair_src), W'(1));
    step();
    rst_n = 1'b0;
    #1;
    check("rstpres_pv_low", W'(pair_valid), W'(0));
    check("rstpres_ack", W'(src_ack), W'(0));
    check("rstpres_strobe", W'(decoder_read_now), W'(0));
    check("rstpres_busy", W'(busy), W'(1));
    check("rstpres_sync_err", W'(sync_err), W'(0));
    check("rstpres_dec_in", dec_in, '0);
    sb.delete();
    mon_hi = 1'b1;
    step();
    rst_n = 1'b1;
    resync_check("resync_rst", 2);

    // After reset, source 0 has first priority again.
    step();
    pair_ready = 1'b1;
    load(0, mkw(8'h5A), 0);
    load(0, mkw(8'h5B), 0);
    load(1, mkw(8'h6A), 0);
    load(1, mkw(8'h6B), 0);
    sb.push_back('{0, mkw(8'h5A), mkw(8'h5B), 4});
    sb.push_back('{1, mkw(8'h6A), mkw(8'h6B), 4});
    wait_sb(100, "post_reset");
    wait_pv(1'b0, 10, "post_reset_pv_fall");
    check("final_sync_err", W'(sync_err), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
